arbitro_funcionalidade: RTL

ARBITRO_FUNCIONALIDADE -- requirements
Module: arbitro_funcionalidade

---
 rtl/arbitro_funcionalidade_pkg.sv | 27 ++
 rtl/arbitro_funcionalidade_if.sv | 27 ++
 rtl/arbitro_funcionalidade_decisor_prioridade.sv | 18 +
 rtl/arbitro_funcionalidade.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arbitro_funcionalidade_pkg.sv
// Shared vehicle definitions: arbiter state encoding, neutral codes and the
// default automatic-pilot user code.
package pkg_veiculo;

    localparam logic [2:0] FUNC_NEUTRO    = 3'b000;
    localparam logic [2:0] USER_NENHUM    = 3'b000;
    localparam logic [2:0] PILOTO_COD_DEF = 3'b111;

    typedef enum logic [2:0] {
        LIVRE  = 3'd0,
        USO0   = 3'd1,
        USO1   = 3'd2,
        AMBOS  = 3'd3,
        PILOTO = 3'd4
    } estado_t;

    // Grant vector driven by each state: bit0 = user 0, bit1 = user 1.
    function automatic logic [1:0] gnt_de(input estado_t e);
        case (e)
            USO0:    gnt_de = 2'b01;
            USO1:    gnt_de = 2'b10;
            AMBOS:   gnt_de = 2'b11;
            default: gnt_de = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/arbitro_funcionalidade_if.sv
// Request/grant bundle between the two users and the functionality arbiter.
// Handshake: a request is offered by holding req/user/func stable; it is
// honoured when the arbiter returns the matching gnt bit one edge later and
// stays granted for as long as the request remains valid.
interface arbitro_funcionalidade_if;
    logic       req0;
    logic       req1;
    logic [2:0] user0;
    logic [2:0] user1;
    logic [2:0] func0;
    logic [2:0] func1;
    logic [1:0] gnt;
    logic [2:0] func_sel0;
    logic [2:0] func_sel1;
    logic       piloto;
    logic       ocupado;

    modport master (
        output req0, req1, user0, user1, func0, func1,
        input  gnt, func_sel0, func_sel1, piloto, ocupado
    );

    modport slave (
        input  req0, req1, user0, user1, func0, func1,
        output gnt, func_sel0, func_sel1, piloto, ocupado
    );
endinterface

// File: rtl/arbitro_funcionalidade_decisor_prioridade.sv
// Priority/tie decision between two users asking for the same functionality.
// Higher user code wins; equal codes go to the user not marked by ultimo.
module decisor_prioridade (
    input  logic [2:0] user0_i,
    input  logic [2:0] user1_i,
    input  logic       ultimo_i,   // 0 = user 0 was granted last, 1 = user 1
    output logic       vence1_o    // 1 = user 1 wins, 0 = user 0 wins
);
    // Pure combinational comparison; the tie goes away from the last winner.
    always_comb begin
        vence1_o = 1'b0;
        if (user1_i > user0_i) begin
            vence1_o = 1'b1;
        end else if (user1_i == user0_i) begin
            vence1_o = ~ultimo_i;
        end
    end
endmodule

// File: rtl/arbitro_funcionalidade.sv
// Two-user functionality arbiter with minimum hold time, shared grant when
// functions differ, and an automatic-pilot mode when both users carry the
// pilot code. All outputs come straight from registers.
module arbitro_funcionalidade
    import pkg_veiculo::*;
#(
    parameter int         HOLD_CYC   = 8,
    parameter logic [2:0] PILOTO_COD = PILOTO_COD_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    arbitro_funcionalidade_if.slave       bus,
    output estado_t                       estado_o
);
    localparam logic [7:0] HOLD_INI = 8'(HOLD_CYC - 1);

    estado_t    state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] fsel0_q, fsel0_d, fsel1_q, fsel1_d;
    logic [2:0] usr0_q, usr0_d, usr1_q, usr1_d;
    logic       ultimo_q, ultimo_d;
    logic [1:0] gnt_q;
    logic       piloto_q, ocupado_q;

    logic v0, v1, piloto_req, vence1, lat0, lat1;

    // Request qualification and the pilot condition on live inputs.
    always_comb begin
        v0 = bus.req0 && (bus.user0 != USER_NENHUM) && (bus.func0 != FUNC_NEUTRO);
        v1 = bus.req1 && (bus.user1 != USER_NENHUM) && (bus.func1 != FUNC_NEUTRO);
        piloto_req = v0 && v1 && (bus.user0 == PILOTO_COD) && (bus.user1 == PILOTO_COD);
    end

    decisor_prioridade u_decisor (
        .user0_i  (bus.user0),
        .user1_i  (bus.user1),
        .ultimo_i (ultimo_q),
        .vence1_o (vence1)
    );

    // Next-state, hold counter and latch decisions.
    always_comb begin
        state_d  = state_q;
        fsel0_d  = fsel0_q;
        fsel1_d  = fsel1_q;
        usr0_d   = usr0_q;
        usr1_d   = usr1_q;
        ultimo_d = ultimo_q;
        cnt_d    = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
        lat0     = 1'b0;
        lat1     = 1'b0;

        if (piloto_req) begin
            state_d = PILOTO;
        end else begin
            case (state_q)
                LIVRE: begin
                    if (v0 && v1) begin
                        if (bus.func0 != bus.func1) begin
                            state_d = AMBOS; lat0 = 1'b1; lat1 = 1'b1;
                        end else if (vence1) begin
                            state_d = USO1; lat1 = 1'b1;
                        end else begin
                            state_d = USO0; lat0 = 1'b1;
                        end
                    end else if (v0) begin
                        state_d = USO0; lat0 = 1'b1;
                    end else if (v1) begin
                        state_d = USO1; lat1 = 1'b1;
                    end
                end
                USO0: begin
                    if (!v0) begin
                        // Owner leaving while the other asks: hand over directly.
                        if (v1) begin
                            state_d = USO1; lat1 = 1'b1;
                        end else begin
                            state_d = LIVRE;
                        end
                    end else if (v1 && (bus.func1 != fsel0_q)) begin
                        state_d = AMBOS; lat1 = 1'b1;
                    end else if (v1 && (bus.user1 > usr0_q) && (cnt_q == 8'd0)) begin
                        state_d = USO1; lat1 = 1'b1;
                    end
                end
                USO1: begin
                    if (!v1) begin
                        if (v0) begin
                            state_d = USO0; lat0 = 1'b1;
                        end else begin
                            state_d = LIVRE;
                        end
                    end else if (v0 && (bus.func0 != fsel1_q)) begin
                        state_d = AMBOS; lat0 = 1'b1;
                    end else if (v0 && (bus.user0 > usr1_q) && (cnt_q == 8'd0)) begin
                        state_d = USO0; lat0 = 1'b1;
                    end
                end
                AMBOS: begin
                    // The survivor keeps the values it latched when granted.
                    if (!v0 && !v1) begin
                        state_d = LIVRE;
                    end else if (!v1) begin
                        state_d = USO0;
                    end else if (!v0) begin
                        state_d = USO1;
                    end else if (bus.func0 == bus.func1) begin
                        if (vence1) begin
                            state_d = USO1; lat1 = 1'b1;
                        end else begin
                            state_d = USO0; lat0 = 1'b1;
                        end
                    end
                end
                PILOTO: begin
                    state_d = LIVRE;
                end
                default: begin
                    state_d = LIVRE;
                end
            endcase
        end

        if ((state_d != state_q) &&
            ((state_d == USO0) || (state_d == USO1) || (state_d == AMBOS))) begin
            cnt_d = HOLD_INI;
        end
        if (lat0) begin
            fsel0_d = bus.func0;
            usr0_d  = bus.user0;
        end
        if (lat1) begin
            fsel1_d = bus.func1;
            usr1_d  = bus.user1;
        end
        if (!((state_d == USO0) || (state_d == AMBOS))) begin
            fsel0_d = FUNC_NEUTRO;
            usr0_d  = USER_NENHUM;
        end
        if (!((state_d == USO1) || (state_d == AMBOS))) begin
            fsel1_d = FUNC_NEUTRO;
            usr1_d  = USER_NENHUM;
        end
        if (state_d != state_q) begin
            if (state_d == USO0) ultimo_d = 1'b0;
            if (state_d == USO1) ultimo_d = 1'b1;
        end
    end

    // Single state register; outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LIVRE;
            cnt_q     <= 8'd0;
            fsel0_q   <= FUNC_NEUTRO;
            fsel1_q   <= FUNC_NEUTRO;
            usr0_q    <= USER_NENHUM;
            usr1_q    <= USER_NENHUM;
            ultimo_q  <= 1'b1;
            gnt_q     <= 2'b00;
            piloto_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fsel0_q   <= fsel0_d;
            fsel1_q   <= fsel1_d;
            usr0_q    <= usr0_d;
            usr1_q    <= usr1_d;
            ultimo_q  <= ultimo_d;
            gnt_q     <= gnt_de(state_d);
            piloto_q  <= (state_d == PILOTO);
            ocupado_q <= (state_d != LIVRE);
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.func_sel0 = fsel0_q;
    assign bus.func_sel1 = fsel1_q;
    assign bus.piloto    = piloto_q;
    assign bus.ocupado   = ocupado_q;
    assign estado_o      = state_q;

endmodule
